stack_call_ctrl: RTL and testbench

//   Initiator side of the hardware call/return stack interface. Accepts one-cycle call/return/jump

---
 rtl/stack_call_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_stack_call_ctrl.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_call_ctrl.sv
// rtl/stack_call_ctrl.sv - initiator controller for the hardware call/return stack
//
// Purpose:
//   Turns one-cycle call/return/jump requests from the instruction sequencer
//   into push/pop/jump strobes for a DEPTH-entry, DATA_W-bit return stack.
//   Tracks occupancy, hands popped return addresses back with a one-cycle
//   valid pulse, and keeps sticky overflow/underflow flags.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_call/ret/jmp    requests, sampled only while req_ready=1
//   call_addr           return address to push on a call
//   jmp_ptr             new stack pointer / depth for a jump
//   clr_err             clears sticky overflow/underflow
//   stk_peek            popped data coming back from the stack
//   req_ready           controller idle, a request is accepted this cycle
//   ret_valid/addr/err  return result pulse, held address, underflow qualifier
//   stk_push/pop/jmp    one-hot strobes to the stack
//   stk_inn, stk_jump   push data and jump pointer to the stack
//   depth               current occupancy, 0..DEPTH
//   overflow/underflow  sticky error flags
module stack_call_ctrl #(
    parameter int DATA_W  = 16,
    parameter int PTR_W   = 5,
    parameter int DEPTH   = 32,
    parameter int POP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_call,
    input  logic              req_ret,
    input  logic              req_jmp,
    input  logic [DATA_W-1:0] call_addr,
    input  logic [PTR_W-1:0]  jmp_ptr,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] stk_peek,
    output logic              req_ready,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_addr,
    output logic              ret_err,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_jmp,
    output logic [DATA_W-1:0] stk_inn,
    output logic [PTR_W-1:0]  stk_jump,
    output logic [PTR_W:0]    depth,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_POP_WAIT,
        S_JMP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_ready;
    logic                r_ret_valid;
    logic [DATA_W-1:0]   r_ret_addr;
    logic                r_ret_err;
    logic                r_stk_push;
    logic                r_stk_pop;
    logic                r_stk_jmp;
    logic [DATA_W-1:0]   r_stk_inn;
    logic [PTR_W-1:0]    r_stk_jump;
    logic [CNT_W-1:0]    r_depth;
    logic                r_overflow;
    logic                r_underflow;

    logic w_idle;
    logic w_do_ret;
    logic w_do_call;
    logic w_do_jmp;
    logic w_full;
    logic w_empty;
    logic w_ret_ok;
    logic w_ret_uf;
    logic w_call_ok;
    logic w_call_of;
    logic w_wait_done;

    // Request arbitration: ret beats call beats jmp; losers are dropped.
    assign w_idle      = (r_state == S_IDLE);
    assign w_do_ret    = w_idle & req_ret;
    assign w_do_call   = w_idle & ~req_ret & req_call;
    assign w_do_jmp    = w_idle & ~req_ret & ~req_call & req_jmp;
    assign w_full      = (r_depth == CNT_W'(DEPTH));
    assign w_empty     = (r_depth == '0);
    assign w_ret_ok    = w_do_ret & ~w_empty;
    assign w_ret_uf    = w_do_ret & w_empty;
    assign w_call_ok   = w_do_call & ~w_full;
    assign w_call_of   = w_do_call & w_full;
    // r_wait counts the POP_WAIT cycles already spent, starting at 0.
    assign w_wait_done = (r_state == S_POP_WAIT) && (r_wait == WAIT_W'(POP_LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Refused calls/rets never leave IDLE, so the sequencer keeps req_ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ret_ok) begin
                    w_next = S_POP;
                end else if (w_call_ok) begin
                    w_next = S_PUSH;
                end else if (w_do_jmp) begin
                    w_next = S_JMP;
                end
            end
            S_PUSH:     w_next = S_IDLE;
            S_POP:      w_next = S_POP_WAIT;
            S_POP_WAIT: if (w_wait_done) w_next = S_IDLE;
            S_JMP:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait      <= '0;
            r_ready     <= 1'b1;
            r_ret_valid <= 1'b0;
            r_ret_addr  <= '0;
            r_ret_err   <= 1'b0;
            r_stk_push  <= 1'b0;
            r_stk_pop   <= 1'b0;
            r_stk_jmp   <= 1'b0;
            r_stk_inn   <= '0;
            r_stk_jump  <= '0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ready    <= (w_next == S_IDLE);
            r_stk_push <= (w_next == S_PUSH);
            r_stk_pop  <= (w_next == S_POP);
            r_stk_jmp  <= (w_next == S_JMP);

            if (w_call_ok) begin
                r_stk_inn <= call_addr;
            end
            if (w_do_jmp) begin
                r_stk_jump <= jmp_ptr;
            end

            // Depth only moves in the cycle the strobe is on the bus; the
            // accept-time guards already rule out wrapping past 0 or DEPTH.
            case (r_state)
                S_PUSH:  r_depth <= r_depth + CNT_W'(1);
                S_POP:   r_depth <= r_depth - CNT_W'(1);
                S_JMP:   r_depth <= CNT_W'(r_stk_jump);
                default: r_depth <= r_depth;
            endcase

            if (r_state == S_POP_WAIT) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end

            r_ret_valid <= w_ret_uf | w_wait_done;
            r_ret_err   <= w_ret_uf;
            if (w_wait_done) begin
                r_ret_addr <= stk_peek;
            end

            // A new error in the same cycle as clr_err is kept.
            r_overflow  <= w_call_of | (r_overflow & ~clr_err);
            r_underflow <= w_ret_uf | (r_underflow & ~clr_err);
        end
    end

    assign req_ready = r_ready;
    assign ret_valid = r_ret_valid;
    assign ret_addr  = r_ret_addr;
    assign ret_err   = r_ret_err;
    assign stk_push  = r_stk_push;
    assign stk_pop   = r_stk_pop;
    assign stk_jmp   = r_stk_jmp;
    assign stk_inn   = r_stk_inn;
    assign stk_jump  = r_stk_jump;
    assign depth     = r_depth;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_call_ctrl.sv
// tb/tb_stack_call_ctrl.sv - self-checking bench for stack_call_ctrl
module tb_stack_call_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_call;
    logic        req_ret;
    logic        req_jmp;
    logic [15:0] call_addr;
    logic [4:0]  jmp_ptr;
    logic        clr_err;
    logic [15:0] stk_peek;
    logic        req_ready;
    logic        ret_valid;
    logic [15:0] ret_addr;
    logic        ret_err;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_jmp;
    logic [15:0] stk_inn;
    logic [4:0]  stk_jump;
    logic [5:0]  depth;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [15:0] last_ret;

    always #5 clk = ~clk;

    stack_call_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_call  (req_call),
        .req_ret   (req_ret),
        .req_jmp   (req_jmp),
        .call_addr (call_addr),
        .jmp_ptr   (jmp_ptr),
        .clr_err   (clr_err),
        .stk_peek  (stk_peek),
        .req_ready (req_ready),
        .ret_valid (ret_valid),
        .ret_addr  (ret_addr),
        .ret_err   (ret_err),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_jmp   (stk_jmp),
        .stk_inn   (stk_inn),
        .stk_jump  (stk_jump),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Stack model with one cycle of pop latency.
    logic [15:0] mem [0:31];
    logic [5:0]  sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= '0;
            stk_peek <= '0;
        end else if (stk_push) begin
            mem[sp[4:0]] <= stk_inn;
            sp           <= sp + 6'd1;
        end else if (stk_pop) begin
            stk_peek <= mem[5'(sp - 6'd1)];
            sp       <= sp - 6'd1;
        end else if (stk_jmp) begin
            sp <= {1'b0, stk_jump};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_call  = 1'b0;
        req_ret   = 1'b0;
        req_jmp   = 1'b0;
        clr_err   = 1'b0;
        call_addr = '0;
        jmp_ptr   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        exp_q.delete();
        last_ret = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 50) begin
            cyc();
            n++;
        end
        if (!req_ready) n = -1;
    endtask

    task automatic wait_ret(output int n);
        n = 0;
        while (!ret_valid && n < 20) begin
            cyc();
            n++;
        end
        if (!ret_valid) n = -1;
    endtask

    task automatic issue_call(input logic [15:0] addr);
        int n;
        call_addr = addr;
        req_call  = 1'b1;
        cyc();
        req_call  = 1'b0;
        wait_ready(n);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_call  = 1'b1;
        req_ret   = 1'b1;
        req_jmp   = 1'b1;
        call_addr = 16'hFFFF;
        jmp_ptr   = 5'h1F;
        clr_err   = 1'b0;
        cyc();
        cyc();
        total++;
        if ({req_ready, ret_valid, ret_err, stk_push, stk_pop, stk_jmp} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready, ret_valid, ret_err, stk_push, stk_pop, stk_jmp});
        end
        total++;
        if ({ret_addr, stk_inn, stk_jump} !== 37'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {ret_addr, stk_inn, stk_jump});
        end
        total++;
        if ({depth, overflow, underflow} !== 8'd0) begin
            bad++;
            $display("FAIL reset_status: got %h want 0", {depth, overflow, underflow});
        end
        idle_inputs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_call();
        call_addr = 16'h1234;
        req_call  = 1'b1;
        cyc();
        req_call  = 1'b0;
        total++;
        if ({stk_push, stk_inn, req_ready, depth} !== {1'b1, 16'h1234, 1'b0, 6'd0}) begin
            bad++;
            $display("FAIL call_n1: got push=%b inn=%h rdy=%b depth=%0d want 1 1234 0 0", stk_push, stk_inn, req_ready, depth);
        end
        cyc();
        total++;
        if ({stk_push, req_ready, depth} !== {1'b0, 1'b1, 6'd1}) begin
            bad++;
            $display("FAIL call_n2: got push=%b rdy=%b depth=%0d want 0 1 1", stk_push, req_ready, depth);
        end
    endtask

    task automatic test_push_ret();
        int n;
        logic [16:0] e;
        do_reset();
        issue_call(16'hA5A5);
        req_ret = 1'b1;
        exp_q.push_back({1'b0, 16'hA5A5});
        last_ret = 16'hA5A5;
        cyc();
        req_ret = 1'b0;
        total++;
        if ({stk_pop, stk_push, depth} !== {1'b1, 1'b0, 6'd1}) begin
            bad++;
            $display("FAIL ret_pop: got pop=%b push=%b depth=%0d want 1 0 1", stk_pop, stk_push, depth);
        end
        wait_ret(n);
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL ret_latency: got %0d want 2 cycles after N+1", n);
        end
        if (n >= 0) begin
            e = exp_q.pop_front();
            total++;
            if ({ret_err, ret_addr} !== e) begin
                bad++;
                $display("FAIL ret_data: got %h want %h", {ret_err, ret_addr}, e);
            end
            total++;
            if ({req_ready, depth} !== {1'b1, 6'd0}) begin
                bad++;
                $display("FAIL ret_idle: got rdy=%b depth=%0d want 1 0", req_ready, depth);
            end
        end
        cyc();
        total++;
        if ({ret_valid, ret_addr} !== {1'b0, 16'hA5A5}) begin
            bad++;
            $display("FAIL ret_pulse: got valid=%b addr=%h want 0 a5a5", ret_valid, ret_addr);
        end
    endtask

    task automatic test_underflow();
        logic [16:0] e;
        req_ret = 1'b1;
        exp_q.push_back({1'b1, last_ret});
        cyc();
        req_ret = 1'b0;
        e = exp_q.pop_front();
        total++;
        if ({stk_pop, ret_valid, underflow, req_ready} !== 4'b0111) begin
            bad++;
            $display("FAIL uf_flags: got pop=%b valid=%b uf=%b rdy=%b want 0 1 1 1", stk_pop, ret_valid, underflow, req_ready);
        end
        total++;
        if ({ret_err, ret_addr} !== e) begin
            bad++;
            $display("FAIL uf_data: got %h want %h", {ret_err, ret_addr}, e);
        end
        cyc();
        total++;
        if ({ret_valid, underflow} !== 2'b01) begin
            bad++;
            $display("FAIL uf_sticky: got valid=%b uf=%b want 0 1", ret_valid, underflow);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        total++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL uf_clear: got %b want 0", underflow);
        end
    endtask

    task automatic test_overflow();
        int n;
        int pushes;
        do_reset();
        pushes = 0;
        n = 0;
        for (int i = 0; i < 33; i++) begin
            call_addr = 16'(i * 3 + 1);
            req_call  = 1'b1;
            cyc();
            req_call  = 1'b0;
            if (stk_push) pushes++;
            wait_ready(n);
        end
        total++;
        if (pushes !== 32) begin
            bad++;
            $display("FAIL ovf_pushes: got %0d want 32", pushes);
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL ovf_ready: got wait %0d want 0", n);
        end
        total++;
        if ({depth, overflow} !== {6'd32, 1'b1}) begin
            bad++;
            $display("FAIL ovf_state: got depth=%0d ovf=%b want 32 1", depth, overflow);
        end
        req_call = 1'b1;
        clr_err  = 1'b1;
        cyc();
        req_call = 1'b0;
        total++;
        if ({overflow, stk_push} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_set_wins: got ovf=%b push=%b want 1 0", overflow, stk_push);
        end
        cyc();
        clr_err = 1'b0;
        total++;
        if ({depth, overflow} !== {6'd32, 1'b0}) begin
            bad++;
            $display("FAIL ovf_clear: got depth=%0d ovf=%b want 32 0", depth, overflow);
        end
    endtask

    task automatic test_priority_jmp();
        int n;
        logic [16:0] e;
        do_reset();
        issue_call(16'h1111);
        issue_call(16'h2222);
        call_addr = 16'h3333;
        req_call  = 1'b1;
        req_ret   = 1'b1;
        exp_q.push_back({1'b0, 16'h2222});
        cyc();
        req_call  = 1'b0;
        req_ret   = 1'b0;
        total++;
        if ({stk_pop, stk_push} !== 2'b10) begin
            bad++;
            $display("FAIL prio_strobe: got pop=%b push=%b want 1 0", stk_pop, stk_push);
        end
        wait_ret(n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL prio_timeout: got no ret_valid want pulse");
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({ret_err, ret_addr, depth} !== {e, 6'd1}) begin
                bad++;
                $display("FAIL prio_data: got %h depth=%0d want %h 1", {ret_err, ret_addr}, depth, e);
            end
        end
        jmp_ptr = 5'd7;
        req_jmp = 1'b1;
        cyc();
        req_jmp   = 1'b0;
        call_addr = 16'h4444;
        req_call  = 1'b1;
        total++;
        if ({stk_jmp, stk_jump, stk_push, stk_pop} !== {1'b1, 5'd7, 2'b00}) begin
            bad++;
            $display("FAIL jmp_strobe: got jmp=%b ptr=%0d push=%b pop=%b want 1 7 0 0", stk_jmp, stk_jump, stk_push, stk_pop);
        end
        cyc();
        req_call = 1'b0;
        total++;
        if ({depth, req_ready, stk_jmp} !== {6'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL jmp_depth: got depth=%0d rdy=%b jmp=%b want 7 1 0", depth, req_ready, stk_jmp);
        end
        cyc();
        total++;
        if ({stk_push, depth} !== {1'b0, 6'd7}) begin
            bad++;
            $display("FAIL busy_ignored: got push=%b depth=%0d want 0 7", stk_push, depth);
        end
    endtask

    task automatic test_reset_pop_wait();
        int seen;
        do_reset();
        issue_call(16'h0101);
        issue_call(16'hBEEF);
        req_ret = 1'b1;
        cyc();
        req_ret = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        total++;
        if ({stk_push, stk_pop, stk_jmp, ret_valid, req_ready, depth} !== {5'b00001, 6'd0}) begin
            bad++;
            $display("FAIL rst_popwait: got %b depth=%0d want 00001 0", {stk_push, stk_pop, stk_jmp, ret_valid, req_ready}, depth);
        end
        cyc();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (ret_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_no_ret: got %0d pulses want 0", seen);
        end
        call_addr = 16'h7777;
        req_call  = 1'b1;
        cyc();
        req_call  = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({stk_push, stk_inn} !== 17'd0) begin
            bad++;
            $display("FAIL rst_async_push: got push=%b inn=%h want 0 0", stk_push, stk_inn);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        int n;
        int k;
        logic [15:0] lifo[$];
        logic [15:0] a;
        logic [16:0] e;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            k = int'($urandom_range(1, 5));
            for (int i = 0; i < k; i++) begin
                a = 16'($urandom);
                lifo.push_back(a);
                issue_call(a);
            end
            for (int i = 0; i < k; i++) begin
                req_ret = 1'b1;
                exp_q.push_back({1'b0, lifo.pop_back()});
                cyc();
                req_ret = 1'b0;
                wait_ret(n);
                total++;
                if (n !== 2) begin
                    bad++;
                    $display("FAIL b2b_latency: got %0d want 2", n);
                end
                if (n >= 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({ret_err, ret_addr} !== e) begin
                        bad++;
                        $display("FAIL b2b_data: got %h want %h", {ret_err, ret_addr}, e);
                    end
                end
            end
            total++;
            if (depth !== 6'd0) begin
                bad++;
                $display("FAIL b2b_depth: got %0d want 0", depth);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        last_ret = '0;
        test_reset();
        test_call();
        test_push_ret();
        test_underflow();
        test_overflow();
        test_priority_jmp();
        test_reset_pop_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
